// File: rtl/td4_fetch_pkg.sv
// Shared TD4 operation definitions: opcode enum and the instruction decode helper.
package td4_fetch_pkg;

  // Legal opcodes carry their own encoding so a waveform reads like the listing.
  typedef enum logic [3:0] {
    OpAddAImm = 4'h0,
    OpMovAB   = 4'h1,
    OpInA     = 4'h2,
    OpMovAImm = 4'h3,
    OpMovBA   = 4'h4,
    OpAddBImm = 4'h5,
    OpInB     = 4'h6,
    OpMovBImm = 4'h7,
    OpInvalid = 4'h8,
    OpOutB    = 4'h9,
    OpOutImm  = 4'hB,
    OpJncImm  = 4'hE,
    OpJmpImm  = 4'hF
  } opecode_e;

  typedef struct packed {
    opecode_e   op;
    logic [3:0] imm;
  } inst_t;

  function automatic inst_t decode_inst(input logic [7:0] inst);
    inst_t d;
    d.imm = inst[3:0];
    case (inst[7:4])
      4'h0:    d.op = OpAddAImm;
      4'h1:    d.op = OpMovAB;
      4'h2:    d.op = OpInA;
      4'h3:    d.op = OpMovAImm;
      4'h4:    d.op = OpMovBA;
      4'h5:    d.op = OpAddBImm;
      4'h6:    d.op = OpInB;
      4'h7:    d.op = OpMovBImm;
      4'h9:    d.op = OpOutB;
      4'hB:    d.op = OpOutImm;
      4'hE:    d.op = OpJncImm;
      4'hF:    d.op = OpJmpImm;
      default: d.op = OpInvalid;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/td4_fetch_tick_gen.sv
// Free-running prescaler; tick is high for one cycle every DIV cycles (always high for DIV=1).
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == CntMax);
  assign cnt_d = tick ? '0 : cnt_q + CntW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/td4_fetch.sv
// TD4 fetch/decode sequencer: tick-paced ROM fetch, valid/ready issue, wait for commit.
// Optional single-step input enabled by defining TD4_FETCH_STEP_EN.
module td4_fetch
  import td4_fetch_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] pc,
  input  logic       halt,
  output logic       mem_rd,
  output logic [3:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic       op_valid,
  input  logic       op_ready,
  output opecode_e   opecode,
  output logic [3:0] imm,
  input  logic       exec_done,
`ifdef TD4_FETCH_STEP_EN
  input  logic       step,
`endif
  output logic       busy
);

  typedef enum logic [2:0] {StIdle, StReq, StCapt, StIssue, StRetire} state_e;

  state_e     state_q, state_d;
  logic       mem_rd_q, mem_rd_d;
  logic [3:0] mem_addr_q, mem_addr_d;
  logic       op_valid_q, op_valid_d;
  opecode_e   opecode_q, opecode_d;
  logic [3:0] imm_q, imm_d;
  logic       tick;
  logic       launch;
  inst_t      dec;

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

`ifdef TD4_FETCH_STEP_EN
  logic step_q, step_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q      <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      step_q      <= step;
      step_prev_q <= step_q;
    end
  end

  // A step edge only matters while halted; only IDLE looks at launch.
  assign launch = (tick && !halt) || (halt && step_q && !step_prev_q);
`else
  assign launch = tick && !halt;
`endif

  assign dec = decode_inst(mem_rdata);

  always_comb begin
    state_d    = state_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    op_valid_d = op_valid_q;
    opecode_d  = opecode_q;
    imm_d      = imm_q;
    case (state_q)
      StIdle: begin
        if (launch) begin
          state_d    = StReq;
          mem_rd_d   = 1'b1;
          mem_addr_d = pc;
        end
      end
      StReq: state_d = StCapt;
      StCapt: begin
        opecode_d  = dec.op;
        imm_d      = dec.imm;
        op_valid_d = 1'b1;
        state_d    = StIssue;
      end
      StIssue: begin
        if (op_ready) begin
          op_valid_d = 1'b0;
          state_d    = StRetire;
        end
      end
      StRetire: begin
        if (exec_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= 4'h0;
      op_valid_q <= 1'b0;
      opecode_q  <= OpInvalid;
      imm_q      <= 4'h0;
    end else begin
      state_q    <= state_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      op_valid_q <= op_valid_d;
      opecode_q  <= opecode_d;
      imm_q      <= imm_d;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign op_valid = op_valid_q;
  assign opecode  = opecode_q;
  assign imm      = imm_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_td4_fetch.sv
// Directed bench for td4_fetch: DIV=4 main instance plus a DIV=1 instance with commit tied high.
module tb_td4_fetch;
  import td4_fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, halt, op_ready, exec_done;
  logic [3:0] pc;
  logic       mem_rd, op_valid, busy;
  logic [3:0] mem_addr, imm;
  logic [7:0] mem_rdata;
  opecode_e   opecode;
`ifdef TD4_FETCH_STEP_EN
  logic       step;
`endif

  logic [3:0] pc1;
  logic       mem_rd1, op_valid1, busy1;
  logic [3:0] mem_addr1, imm1;
  logic [7:0] mem_rdata1;
  opecode_e   opecode1;

  logic [7:0] rom  [16];
  logic [7:0] rom1 [16];
  opecode_e   exp_op [16];

  int edge_cnt;
  int n_vec = 0;
  int n_err = 0;

  td4_fetch #(.DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc       (pc),
    .halt     (halt),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .opecode  (opecode),
    .imm      (imm),
    .exec_done(exec_done),
`ifdef TD4_FETCH_STEP_EN
    .step     (step),
`endif
    .busy     (busy)
  );

  td4_fetch #(.DIV(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc       (pc1),
    .halt     (1'b0),
    .mem_rd   (mem_rd1),
    .mem_addr (mem_addr1),
    .mem_rdata(mem_rdata1),
    .op_valid (op_valid1),
    .op_ready (1'b1),
    .opecode  (opecode1),
    .imm      (imm1),
    .exec_done(1'b1),
`ifdef TD4_FETCH_STEP_EN
    .step     (1'b0),
`endif
    .busy     (busy1)
  );

  always @(posedge clk) if (mem_rd) mem_rdata <= rom[mem_addr];
  always @(posedge clk) if (mem_rd1) mem_rdata1 <= rom1[mem_addr1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rd(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_rd) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  // Runs one instruction from IDLE through RETIRE; called on a falling edge.
  task automatic fetch_one(input string tag, input logic [3:0] addr, input opecode_e eop,
                           input logic [3:0] eimm, input int stall, input bit raise_halt);
    pc       = addr;
    op_ready = (stall == 0);
    wait_rd(tag);
    check_eq({tag, "_addr"}, mem_addr, addr);
    check_eq({tag, "_phase"}, (edge_cnt - 1) % 4, 3);
    @(negedge clk);
    check_eq({tag, "_vld_early"}, op_valid, 0);
    @(negedge clk);
    check_eq({tag, "_vld"}, op_valid, 1);
    check_eq({tag, "_op"}, opecode, eop);
    check_eq({tag, "_imm"}, imm, eimm);
    if (raise_halt) halt = 1'b1;
    for (int i = 0; i < stall; i++) begin
      check_eq({tag, "_hold"}, {op_valid, mem_rd, 4'(opecode), imm}, {1'b1, 1'b0, eop, eimm});
      @(negedge clk);
    end
    op_ready = 1'b1;
    @(negedge clk);
    check_eq({tag, "_retire"}, {op_valid, busy}, 2'b01);
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    check_eq({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int rd_cnt;
    rst_n     = 1'b0;
    halt      = 1'b1;
    op_ready  = 1'b0;
    exec_done = 1'b0;
    pc        = 4'h0;
    pc1       = 4'h2;
`ifdef TD4_FETCH_STEP_EN
    step      = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin
      rom[i]  = 8'h00;
      rom1[i] = 8'h00;
    end
    rom1[2] = 8'h5A;
    exp_op = '{OpAddAImm, OpMovAB, OpInA, OpMovAImm, OpMovBA, OpAddBImm, OpInB, OpMovBImm,
               OpInvalid, OpOutB, OpInvalid, OpOutImm, OpInvalid, OpInvalid, OpJncImm, OpJmpImm};

    repeat (2) @(negedge clk);
    check_eq("rst_mem_rd", mem_rd, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_op_valid", op_valid, 0);
    check_eq("rst_opecode", opecode, OpInvalid);
    check_eq("rst_imm", imm, 0);
    check_eq("rst_busy", busy, 0);
    rst_n = 1'b1;

    // DIV=1 instance: 5-cycle cadence REQ,CAPT,ISSUE,RETIRE,IDLE from the first edge.
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check_eq("div1_busy", busy1, (k % 5) != 0);
      check_eq("div1_rd", mem_rd1, (k % 5) == 1);
      check_eq("div1_vld", op_valid1, (k % 5) == 3);
      if ((k % 5) == 1) check_eq("div1_addr", mem_addr1, 4'h2);
      if ((k % 5) == 3) check_eq("div1_dec", {4'(opecode1), imm1}, {OpAddBImm, 4'hA});
    end
    check_eq("halted_no_fetch", busy, 0);

    halt   = 1'b0;
    rom[0] = 8'h35;
    fetch_one("mov_a_imm", 4'h0, OpMovAImm, 4'h5, 0, 1'b0);
    rom[1] = 8'hF3;
    fetch_one("jmp_stall", 4'h1, OpJmpImm, 4'h3, 7, 1'b0);

    for (int i = 0; i < 16; i++) begin
      rom[i] = 8'(i << 4);
      fetch_one($sformatf("dec%0d", i), 4'(i), exp_op[i], 4'h0, 0, 1'b0);
    end

    rom[3] = 8'h9C;
    fetch_one("halt_issue", 4'h3, OpOutB, 4'hC, 2, 1'b1);
    rd_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_rd) rd_cnt++;
    end
    check_eq("halt_no_rd", rd_cnt, 0);
    check_eq("halt_idle", busy, 0);

`ifdef TD4_FETCH_STEP_EN
    exec_done = 1'b1;
    step      = 1'b1;
    rd_cnt    = 0;
    repeat (25) begin
      @(negedge clk);
      if (mem_rd) rd_cnt++;
    end
    check_eq("step_one_fetch", rd_cnt, 1);
    check_eq("step_idle", busy, 0);
    step      = 1'b0;
    exec_done = 1'b0;
`endif

    // Asynchronous reset while an instruction sits in ISSUE.
    halt     = 1'b0;
    op_ready = 1'b0;
    rom[4]   = 8'h7E;
    pc       = 4'h4;
    wait_rd("rst_mid");
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_mid_pre", op_valid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_vld", op_valid, 0);
    check_eq("rst_mid_op", opecode, OpInvalid);
    check_eq("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    op_ready = 1'b1;
    wait_rd("post_rst");
    check_eq("post_rst_first_edge", edge_cnt, 4);
    fetch_one("post_rst", 4'h4, OpMovBImm, 4'hE, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
